linebuf_wr_ctrl: RTL and testbench

Sits directly downstream of the TVP7002 front end, in the PCLK_i domain. It takes the front end's pipelined active-video samples (RGB, DE, datavalid, frame_change) and writes valid active pixels into a LB_LINES-deep ring of line slots in a dual-port line buffer. It tracks line occupancy against a downstream reader through a line-done handshake, and flags overflow and underflow.

---
 rtl/linebuf_wr_ctrl_if.sv | 19 +
 rtl/linebuf_wr_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_linebuf_wr_ctrl.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/linebuf_wr_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | linebuf_wr_ctrl_if : write-port bundle between controller and buffer |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface linebuf_wr_ctrl_if #(
  parameter int LB_LINES = 4,
  parameter int PIX_W    = 11
);
  localparam int ADDR_W = $clog2(LB_LINES) + PIX_W;

  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [23:0]       wr_data_o;

  modport master (output wr_en_o, wr_addr_o, wr_data_o);
  modport slave  (input  wr_en_o, wr_addr_o, wr_data_o);
endinterface
`default_nettype wire

// File: rtl/linebuf_wr_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | linebuf_wr_ctrl : writes qualified active pixels into a ring of line |
// | slots and tracks slot occupancy against a downstream reader.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module linebuf_wr_ctrl #(
  parameter int LB_LINES = 4,
  parameter int PIX_W    = 11
) (
  input  wire                          PCLK_i,
  input  wire                          reset,
  input  wire                          enable_i,
  input  wire  [7:0]                   R_i,
  input  wire  [7:0]                   G_i,
  input  wire  [7:0]                   B_i,
  input  wire                          DE_i,
  input  wire                          datavalid_i,
  input  wire                          frame_change_i,
  input  wire  [10:0]                  ypos_i,
  input  wire  [PIX_W-1:0]             h_active_i,
  input  wire                          rd_line_done_i,
  linebuf_wr_ctrl_if.master            wr_if,
  output logic                         line_done_o,
  output logic [10:0]                  line_id_o,
  output logic                         frame_start_o,
  output logic [$clog2(LB_LINES):0]    lines_avail_o,
  output logic                         overflow_o,
  output logic                         underflow_o
);

  localparam int SLOT_W  = $clog2(LB_LINES);
  localparam int AVAIL_W = SLOT_W + 1;
  localparam int ADDR_W  = SLOT_W + PIX_W;

  localparam logic [AVAIL_W-1:0] C_FULL    = AVAIL_W'(LB_LINES);
  localparam logic [PIX_W-1:0]   C_PIX_MAX = {PIX_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_SOF    = 3'd1,
    LINE_WAIT   = 3'd2,
    LINE_ACTIVE = 3'd3,
    LINE_TAIL   = 3'd4,
    LINE_DROP   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [SLOT_W-1:0]   wr_slot_q, wr_slot_d;
  logic [PIX_W-1:0]    pix_cnt_q, pix_cnt_d;
  logic [10:0]         ypos_lat_q, ypos_lat_d;
  logic [AVAIL_W-1:0]  lines_avail_q, lines_avail_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [23:0]         wr_data_q, wr_data_d;
  logic                line_done_q, line_done_d;
  logic [10:0]         line_id_q, line_id_d;
  logic                frame_start_q, frame_start_d;

  logic                sample;
  logic [PIX_W-1:0]    pix_next;
  logic                limit_hit;
  logic                do_write;
  logic                do_commit;
  logic                do_clear;

  assign sample    = DE_i & datavalid_i;
  assign pix_next  = pix_cnt_q + PIX_W'(1);
  assign limit_hit = (h_active_i != '0) && (pix_next == h_active_i);

  always_comb begin
    state_d       = state_q;
    wr_slot_d     = wr_slot_q;
    pix_cnt_d     = pix_cnt_q;
    ypos_lat_d    = ypos_lat_q;
    lines_avail_d = lines_avail_q;
    overflow_d    = overflow_q;
    underflow_d   = underflow_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    line_done_d   = 1'b0;
    line_id_d     = line_id_q;
    frame_start_d = 1'b0;
    do_write      = 1'b0;
    do_commit     = 1'b0;
    do_clear      = 1'b0;

    if (!enable_i) begin
      state_d   = IDLE;
      pix_cnt_d = '0;
    end else if (state_q == IDLE) begin
      state_d     = WAIT_SOF;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else if (frame_change_i) begin
      do_clear = 1'b1;
      state_d  = LINE_WAIT;
    end else begin
      case (state_q)
        LINE_WAIT: begin
          if (sample) begin
            if (lines_avail_q == C_FULL) begin
              overflow_d = 1'b1;
              state_d    = LINE_DROP;
            end else begin
              do_write   = 1'b1;
              ypos_lat_d = ypos_i;
              state_d    = LINE_ACTIVE;
            end
          end
        end
        LINE_ACTIVE: begin
          if (!DE_i) begin
            do_commit = 1'b1;
            state_d   = LINE_WAIT;
          end else if (sample && (pix_cnt_q != C_PIX_MAX)) begin
            do_write = 1'b1;
          end
        end
        LINE_TAIL, LINE_DROP: begin
          if (!DE_i) state_d = LINE_WAIT;
        end
        default: ;
      endcase

      // Reaching the pixel limit always happens on a sample, so DE is still high.
      if (do_write) begin
        pix_cnt_d = pix_next;
        if (limit_hit) begin
          do_commit = 1'b1;
          state_d   = LINE_TAIL;
        end
      end
    end

    if (do_write) begin
      wr_en_d   = 1'b1;
      wr_addr_d = {wr_slot_q, pix_cnt_q};
      wr_data_d = {R_i, G_i, B_i};
    end

    if (do_commit) begin
      line_done_d = 1'b1;
      line_id_d   = ypos_lat_d;
      wr_slot_d   = wr_slot_q + SLOT_W'(1);
      pix_cnt_d   = '0;
    end

    // A ring clear wins over any coincident read or commit.
    if (do_clear) begin
      wr_slot_d     = '0;
      pix_cnt_d     = '0;
      lines_avail_d = '0;
      frame_start_d = 1'b1;
    end else begin
      if (rd_line_done_i && (lines_avail_q == '0)) underflow_d = 1'b1;
      if (do_commit && !rd_line_done_i) begin
        lines_avail_d = lines_avail_q + AVAIL_W'(1);
      end else if (!do_commit && rd_line_done_i && (lines_avail_q != '0)) begin
        lines_avail_d = lines_avail_q - AVAIL_W'(1);
      end
    end
  end

  always_ff @(posedge PCLK_i) begin
    if (reset) begin
      state_q       <= IDLE;
      wr_slot_q     <= '0;
      pix_cnt_q     <= '0;
      ypos_lat_q    <= '0;
      lines_avail_q <= '0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      line_done_q   <= 1'b0;
      line_id_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_slot_q     <= wr_slot_d;
      pix_cnt_q     <= pix_cnt_d;
      ypos_lat_q    <= ypos_lat_d;
      lines_avail_q <= lines_avail_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      line_done_q   <= line_done_d;
      line_id_q     <= line_id_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign wr_if.wr_en_o   = wr_en_q;
  assign wr_if.wr_addr_o = wr_addr_q;
  assign wr_if.wr_data_o = wr_data_q;
  assign line_done_o     = line_done_q;
  assign line_id_o       = line_id_q;
  assign frame_start_o   = frame_start_q;
  assign lines_avail_o   = lines_avail_q;
  assign overflow_o      = overflow_q;
  assign underflow_o     = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_linebuf_wr_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_linebuf_wr_ctrl : scoreboard bench for linebuf_wr_ctrl            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_linebuf_wr_ctrl;

  localparam int LB_LINES = 4;
  localparam int PIX_W    = 11;
  localparam int SLOT_W   = $clog2(LB_LINES);
  localparam int AVAIL_W  = SLOT_W + 1;
  localparam int ADDR_W   = SLOT_W + PIX_W;
  localparam int PIX_MAX  = (1 << PIX_W) - 1;

  // Behavioural model phases
  localparam int P_OFF = 0, P_SOF = 1, P_GAP = 2, P_STORE = 3, P_FULL = 4, P_DROP = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, en, de, dv, fc, rd;
  logic [7:0]         r, g, b;
  logic [10:0]        ypos;
  logic [PIX_W-1:0]   hact;
  logic               line_done, fs, ovf, unf;
  logic [10:0]        line_id;
  logic [AVAIL_W-1:0] avail;

  linebuf_wr_ctrl_if #(.LB_LINES(LB_LINES), .PIX_W(PIX_W)) wif ();

  linebuf_wr_ctrl #(.LB_LINES(LB_LINES), .PIX_W(PIX_W)) dut (
    .PCLK_i         (clk),
    .reset          (rst),
    .enable_i       (en),
    .R_i            (r),
    .G_i            (g),
    .B_i            (b),
    .DE_i           (de),
    .datavalid_i    (dv),
    .frame_change_i (fc),
    .ypos_i         (ypos),
    .h_active_i     (hact),
    .rd_line_done_i (rd),
    .wr_if          (wif.master),
    .line_done_o    (line_done),
    .line_id_o      (line_id),
    .frame_start_o  (fs),
    .lines_avail_o  (avail),
    .overflow_o     (ovf),
    .underflow_o    (unf)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [23:0]       data;
  } wr_t;

  typedef struct packed {
    logic               fs;
    logic [AVAIL_W-1:0] avail;
    logic               ovf;
    logic               unf;
    logic [ADDR_W-1:0]  addr;
    logic [23:0]        data;
    logic [10:0]        id;
  } status_t;

  wr_t         wr_q[$];
  logic [10:0] ld_q[$];
  status_t     st_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: occupancy is a count of committed unread lines, the
  // write slot is simply the number of lines committed this frame mod ring size.
  int                m_phase, m_lines, m_avail, m_pix;
  logic [10:0]       m_id, m_lid;
  logic              m_ovf, m_unf;
  logic [ADDR_W-1:0] m_addr;
  logic [23:0]       m_data;

  function automatic void model_step();
    bit commit = 0;
    bit clear  = 0;
    bit s      = de & dv;
    if (rst) begin
      m_phase = P_OFF; m_lines = 0; m_avail = 0; m_pix = 0; m_id = '0;
      m_lid = '0; m_ovf = 0; m_unf = 0; m_addr = '0; m_data = '0;
    end else begin
      if (!en) begin
        m_phase = P_OFF;
        m_pix   = 0;
      end else if (m_phase == P_OFF) begin
        m_phase = P_SOF;
        m_ovf   = 0;
        m_unf   = 0;
      end else if (fc) begin
        clear   = 1;
        m_phase = P_GAP;
        m_lines = 0;
        m_avail = 0;
        m_pix   = 0;
      end else begin
        bit wrote = 0;
        if (m_phase == P_GAP && s) begin
          if (m_avail == LB_LINES) begin
            m_ovf   = 1;
            m_phase = P_DROP;
          end else begin
            m_id    = ypos;
            m_phase = P_STORE;
            wrote   = 1;
          end
        end else if (m_phase == P_STORE) begin
          if (!de) begin
            commit  = 1;
            m_phase = P_GAP;
          end else if (s && m_pix < PIX_MAX) begin
            wrote = 1;
          end
        end else if ((m_phase == P_FULL || m_phase == P_DROP) && !de) begin
          m_phase = P_GAP;
        end
        if (wrote) begin
          m_addr = ADDR_W'((m_lines % LB_LINES) * (PIX_MAX + 1) + m_pix);
          m_data = {r, g, b};
          wr_q.push_back(wr_t'{addr: m_addr, data: m_data});
          m_pix++;
          if (hact != 0 && m_pix == int'(hact)) begin
            commit  = 1;
            m_phase = P_FULL;
          end
        end
        if (commit) begin
          ld_q.push_back(m_id);
          m_lid = m_id;
          m_lines++;
          m_pix = 0;
        end
      end
      if (!clear && rd) begin
        if (m_avail == 0) m_unf = 1;
        if (!commit && m_avail > 0) m_avail--;
      end else if (!clear && commit) begin
        m_avail++;
      end
    end
    st_q.push_back(status_t'{fs: clear, avail: AVAIL_W'(m_avail), ovf: m_ovf, unf: m_unf,
                             addr: m_addr, data: m_data, id: m_lid});
  endfunction

  // Monitor: pops expectations whenever the DUT presents an output
  wr_t         mon_w;
  logic [10:0] mon_id;
  status_t     mon_s;
  always @(posedge clk) begin
    #1;
    if (wif.wr_en_o === 1'b1) begin
      if (wr_q.size() == 0) begin
        chk("unexpected_write", 32'(wif.wr_addr_o), 32'hFFFF_FFFF);
      end else begin
        mon_w = wr_q.pop_front();
        chk("wr_addr", 32'(wif.wr_addr_o), 32'(mon_w.addr));
        chk("wr_data", 32'(wif.wr_data_o), 32'(mon_w.data));
      end
    end
    if (line_done === 1'b1) begin
      if (ld_q.size() == 0) begin
        chk("unexpected_line_done", 32'(line_id), 32'hFFFF_FFFF);
      end else begin
        mon_id = ld_q.pop_front();
        chk("line_id", 32'(line_id), 32'(mon_id));
      end
    end
    if (st_q.size() != 0) begin
      mon_s = st_q.pop_front();
      chk("frame_start", 32'(fs), 32'(mon_s.fs));
      chk("lines_avail", 32'(avail), 32'(mon_s.avail));
      chk("overflow", 32'(ovf), 32'(mon_s.ovf));
      chk("underflow", 32'(unf), 32'(mon_s.unf));
      chk("wr_addr_hold", 32'(wif.wr_addr_o), 32'(mon_s.addr));
      chk("wr_data_hold", 32'(wif.wr_data_o), 32'(mon_s.data));
      chk("line_id_hold", 32'(line_id), 32'(mon_s.id));
    end
  end

  logic             p_rst, p_en;
  logic [PIX_W-1:0] p_hact;

  task automatic drive(input logic de_v, input logic dv_v, input logic fc_v,
                       input logic rd_v, input logic [10:0] y);
    @(negedge clk);
    rst  = p_rst;
    en   = p_en;
    hact = p_hact;
    de   = de_v;
    dv   = dv_v;
    fc   = fc_v;
    rd   = rd_v;
    ypos = y;
    r    = 8'($urandom);
    g    = 8'($urandom);
    b    = 8'($urandom);
    model_step();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, ypos);
  endtask

  task automatic pulse_read();
    drive(1'b0, 1'b0, 1'b0, 1'b1, ypos);
  endtask

  task automatic frame_pulse();
    drive(1'b0, 1'b0, 1'b1, 1'b0, ypos);
  endtask

  // mode 0: every cycle valid, 1: every second cycle, 2: random
  task automatic line(input logic [10:0] y, input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      logic v;
      v = (mode == 0) ? 1'b1 : (mode == 1) ? 1'((i % 2) == 0) : 1'($urandom_range(0, 1));
      drive(1'b1, v, 1'b0, 1'b0, y);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; de = 1'b0; dv = 1'b0; fc = 1'b0; rd = 1'b0;
    r = '0; g = '0; b = '0; ypos = '0; hact = '0;
    p_rst = 1'b1; p_en = 1'b0; p_hact = '0;

    idle(3);
    chk("reset_wr_en", 32'(wif.wr_en_o), 32'd0);
    chk("reset_wr_addr", 32'(wif.wr_addr_o), 32'd0);
    chk("reset_line_done", 32'(line_done), 32'd0);
    chk("reset_avail", 32'(avail), 32'd0);
    p_rst = 1'b0;

    // Basic line
    p_en = 1'b1;
    idle(2);
    frame_pulse();
    line(11'd5, 8, 0);
    idle(3);
    chk("basic_avail", 32'(avail), 32'd1);

    // Sample skip
    line(11'd6, 16, 1);
    idle(3);
    chk("skip_avail", 32'(avail), 32'd2);

    // h_active limit
    p_hact = PIX_W'(4);
    line(11'd7, 10, 0);
    idle(3);
    p_hact = '0;
    chk("hact_avail", 32'(avail), 32'd3);

    // Overflow with no reads
    frame_pulse();
    idle(2);
    for (int k = 0; k < 5; k++) begin
      line(11'(10 + k), 6, 0);
      idle(2);
    end
    chk("ovf_avail", 32'(avail), 32'd4);
    chk("ovf_flag", 32'(ovf), 32'd1);
    pulse_read();
    idle(1);
    line(11'd20, 6, 0);
    idle(3);
    chk("ovf_refill_avail", 32'(avail), 32'd4);

    // Commit coinciding with a read, then underflow
    frame_pulse();
    line(11'd30, 4, 0);
    idle(2);
    line(11'd31, 4, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 11'd31);
    idle(2);
    chk("simul_avail", 32'(avail), 32'd1);
    chk("simul_unf", 32'(unf), 32'd0);
    pulse_read();
    pulse_read();
    idle(2);
    chk("unf_avail", 32'(avail), 32'd0);
    chk("unf_flag", 32'(unf), 32'd1);

    // Frame change mid-line
    line(11'd40, 3, 0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 11'd40);
    idle(2);
    chk("abort_avail", 32'(avail), 32'd0);
    line(11'd41, 5, 0);
    idle(2);
    chk("abort_next_avail", 32'(avail), 32'd1);

    // Disable mid-line, re-enable clears sticky flags
    line(11'd42, 3, 0);
    p_en = 1'b0;
    idle(2);
    p_en = 1'b1;
    idle(1);
    frame_pulse();
    line(11'd43, 4, 0);
    idle(2);
    chk("reen_avail", 32'(avail), 32'd1);
    chk("reen_ovf", 32'(ovf), 32'd0);
    chk("reen_unf", 32'(unf), 32'd0);

    // Randomised traffic
    begin
      int          run    = 0;
      logic        cur_de = 1'b0;
      logic [10:0] y      = '0;
      for (int c = 0; c < 4000; c++) begin
        if (run == 0) begin
          cur_de = ~cur_de;
          run    = cur_de ? $urandom_range(1, 12) : $urandom_range(1, 5);
          if (cur_de) begin
            y = 11'($urandom);
            if ($urandom_range(0, 3) == 0) begin
              case ($urandom_range(0, 4))
                0: p_hact = PIX_W'(0);
                1: p_hact = PIX_W'(1);
                2: p_hact = PIX_W'(3);
                3: p_hact = PIX_W'(5);
                default: p_hact = PIX_W'(9);
              endcase
            end
          end
        end
        run--;
        p_en  = 1'($urandom_range(0, 299) != 0);
        p_rst = 1'($urandom_range(0, 999) == 0);
        drive(cur_de, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 59) == 0),
              1'($urandom_range(0, 5) == 0), y);
      end
      p_rst = 1'b0;
      p_en  = 1'b1;
      p_hact = '0;
    end

    // Reset asserted mid-line
    idle(2);
    frame_pulse();
    line(11'd50, 3, 0);
    p_rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 11'd50);
    p_rst = 1'b0;
    idle(1);
    chk("rst_mid_wr_en", 32'(wif.wr_en_o), 32'd0);
    chk("rst_mid_wr_addr", 32'(wif.wr_addr_o), 32'd0);
    chk("rst_mid_wr_data", 32'(wif.wr_data_o), 32'd0);
    chk("rst_mid_line_done", 32'(line_done), 32'd0);
    chk("rst_mid_line_id", 32'(line_id), 32'd0);
    chk("rst_mid_avail", 32'(avail), 32'd0);
    chk("rst_mid_flags", 32'({fs, ovf, unf}), 32'd0);
    line(11'd51, 4, 0);
    idle(2);
    chk("rst_idle_avail", 32'(avail), 32'd0);

    idle(3);
    @(posedge clk);
    #2;
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    chk("ld_q_drained", 32'(ld_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
